// File: rtl/gray_pkg.sv
// Shared types and defaults for the Gray-sequence checker: FSM states,
// step classes and default word width / lock threshold.
package gray_pkg;

   localparam int GRAY_WIDTH      = 4;
   localparam int GRAY_LOCK_COUNT = 2;
   localparam int GRAY_ERR_W      = 8;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      STEP_INC  = 2'd0,
      STEP_HOLD = 2'd1,
      STEP_BAD  = 2'd2
   } step_t;

endpackage

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter: each binary bit is the
// XOR of all Gray bits at or above its position.
module gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/gray_seq_checker.sv
// Monitors a Gray-code counter stream, checks each valid sample is a +1 step,
// and reports lock, step errors and wrap. Define GRAY_HOLD_ERR_EN to treat a
// repeated word (generator stall) as a sequence error.
module gray_seq_checker
   import gray_pkg::*;
#(
   parameter int WIDTH      = GRAY_WIDTH,
   parameter int LOCK_COUNT = GRAY_LOCK_COUNT,
   parameter int ERR_W      = GRAY_ERR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             valid_in,
   input  logic             clr_err,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             locked,
   output logic             step_err,
   output logic             wrap,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t           state;
   step_t            step;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] bin_now;
   logic [3:0]       good_cnt;
   logic [3:0]       next_good;

   gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
      .gray (gray_in),
      .bin  (bin_now)
   );

   assign next_good = good_cnt + 4'd1;

   // With the hold-error option a repeated word is simply classified as BAD,
   // which gives the same LOCKING and LOCKED behaviour as any other violation.
   always_comb begin
      step = STEP_BAD;
      if (bin_now == prev + WIDTH'(1)) begin
         step = STEP_INC;
      end else if (bin_now == prev) begin
`ifdef GRAY_HOLD_ERR_EN
         step = STEP_BAD;
`else
         step = STEP_HOLD;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= SEARCH;
         prev      <= '0;
         good_cnt  <= '0;
         bin_out   <= '0;
         bin_valid <= 1'b0;
         locked    <= 1'b0;
         step_err  <= 1'b0;
         wrap      <= 1'b0;
         err_count <= '0;
      end else begin
         bin_valid <= 1'b0;
         step_err  <= 1'b0;
         wrap      <= 1'b0;
         if (valid_in) begin
            bin_out   <= bin_now;
            bin_valid <= 1'b1;
            prev      <= bin_now;
            case (state)
               SEARCH: begin
                  state    <= LOCKING;
                  good_cnt <= '0;
               end
               LOCKING: begin
                  case (step)
                     STEP_INC: begin
                        if (next_good == 4'(LOCK_COUNT)) begin
                           state    <= LOCKED;
                           locked   <= 1'b1;
                           good_cnt <= '0;
                        end else begin
                           good_cnt <= next_good;
                        end
                     end
                     STEP_HOLD: ;
                     default:   good_cnt <= '0;
                  endcase
               end
               LOCKED: begin
                  case (step)
                     STEP_INC:  wrap <= (prev == '1);
                     STEP_HOLD: ;
                     default: begin
                        step_err <= 1'b1;
                        if (err_count != ERR_MAX) begin
                           err_count <= err_count + ERR_W'(1);
                        end
                        state    <= LOCKING;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                     end
                  endcase
               end
               default: begin
                  state    <= SEARCH;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
            endcase
         end
         // Clearing wins over a same-cycle increment.
         if (clr_err) begin
            err_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Scoreboard bench for gray_seq_checker: a behavioural model queues the
// expected outputs for every driven cycle and each scenario task compares them.
module tb_gray_seq_checker;

   logic       clk;
   logic       reset;
   logic [3:0] gray_in;
   logic       valid_in;
   logic       clr_err;
   logic [3:0] bin_out;
   logic       bin_valid;
   logic       locked;
   logic       step_err;
   logic       wrap;
   logic [7:0] err_count;

   int checks   = 0;
   int failures = 0;

   logic [15:0] sb[$];
   int          m_state;
   int          m_good;
   int          m_err;
   logic [3:0]  m_prev;
   logic [3:0]  m_bin;

   gray_seq_checker #(.WIDTH(4), .LOCK_COUNT(2), .ERR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .gray_in   (gray_in),
      .valid_in  (valid_in),
      .clr_err   (clr_err),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .locked    (locked),
      .step_err  (step_err),
      .wrap      (wrap),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] g2b(input logic [3:0] g);
      return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
   endfunction

   function automatic logic [3:0] b2g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [15:0] dut_word();
      return {bin_out, bin_valid, locked, step_err, wrap, err_count};
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_good  = 0;
      m_err   = 0;
      m_prev  = 4'd0;
      m_bin   = 4'd0;
      sb.delete();
   endtask

   // Drive one cycle, advance the model, queue its expectation, step past the edge.
   task automatic applyStimulus(input logic [3:0] g, input logic v, input logic c);
      logic [3:0] b;
      logic [3:0] nxt;
      logic       is_inc, is_hold, se, wr, bv;
      se = 1'b0; wr = 1'b0; bv = 1'b0;
      gray_in  = g;
      valid_in = v;
      clr_err  = c;
      if (v) begin
         b       = g2b(g);
         nxt     = m_prev + 4'd1;
         is_inc  = (b == nxt);
         is_hold = (b == m_prev);
`ifdef GRAY_HOLD_ERR_EN
         is_hold = 1'b0;
`endif
         if (m_state == 0) begin
            m_state = 1;
            m_good  = 0;
         end else if (m_state == 1) begin
            if (is_inc) begin
               m_good++;
               if (m_good == 2) begin
                  m_state = 2;
                  m_good  = 0;
               end
            end else if (!is_hold) begin
               m_good = 0;
            end
         end else begin
            if (is_inc) begin
               wr = (m_prev == 4'hF);
            end else if (!is_hold) begin
               se = 1'b1;
               if (m_err < 255) m_err++;
               m_state = 1;
               m_good  = 0;
            end
         end
         m_prev = b;
         m_bin  = b;
         bv     = 1'b1;
      end
      if (c) m_err = 0;
      sb.push_back({m_bin, bv, (m_state == 2), se, wr, 8'(m_err)});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      gray_in  = 4'd0;
      valid_in = 1'b0;
      clr_err  = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_word() !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%h exp=0000", dut_word());
      end
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_sequence();
      logic [3:0] seq[17];
      logic [15:0] e;
      int wraps;
      seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      wraps = 0;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(seq[i], 1'b1, 1'b0);
         e = sb.pop_front();
         checks++;
         if (dut_word() !== e) begin
            failures++;
            $display("[TB] FAIL seq[%0d] got=%h exp=%h", i, dut_word(), e);
         end
         if (wrap === 1'b1) wraps++;
         if (i == 2) begin
            checks++;
            if (locked !== 1'b1) begin
               failures++;
               $display("[TB] FAIL lock_after_third got=%b exp=1", locked);
            end
         end
      end
      checks++;
      if (wraps != 1 || bin_out !== 4'd0 || err_count !== 8'd0) begin
         failures++;
         $display("[TB] FAIL seq_summary wraps=%0d bin=%0d err=%0d exp wraps=1 bin=0 err=0",
                  wraps, bin_out, err_count);
      end
   endtask

   task automatic test_hold();
      logic [3:0] seq[6];
      logic [15:0] e;
      seq = '{4'h1, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(seq[i], 1'b1, 1'b0);
         e = sb.pop_front();
         checks++;
         if (dut_word() !== e) begin
            failures++;
            $display("[TB] FAIL hold[%0d] got=%h exp=%h", i, dut_word(), e);
         end
      end
`ifndef GRAY_HOLD_ERR_EN
      checks++;
      if (locked !== 1'b1 || err_count !== 8'd0) begin
         failures++;
         $display("[TB] FAIL hold_benign locked=%b err=%0d exp locked=1 err=0", locked, err_count);
      end
`endif
   endtask

   task automatic test_step_error();
      logic [3:0] seq[6];
      logic [15:0] e;
      seq = '{4'h2, 4'h6, 4'h5, 4'h4, 4'hC, 4'hD};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(seq[i], 1'b1, 1'b0);
         e = sb.pop_front();
         checks++;
         if (dut_word() !== e) begin
            failures++;
            $display("[TB] FAIL step_err[%0d] got=%h exp=%h", i, dut_word(), e);
         end
`ifndef GRAY_HOLD_ERR_EN
         if (i == 2) begin
            checks++;
            if (step_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
               failures++;
               $display("[TB] FAIL inject se=%b locked=%b err=%0d exp se=1 locked=0 err=1",
                        step_err, locked, err_count);
            end
         end
`endif
         if (i == 4) begin
            checks++;
            if (locked !== 1'b1) begin
               failures++;
               $display("[TB] FAIL relock got=%b exp=1", locked);
            end
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] e;
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < 3; k++) begin
            applyStimulus(b2g(m_prev + ((k == 0) ? 4'd5 : 4'd1)), 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (dut_word() !== e) begin
               failures++;
               $display("[TB] FAIL sat[%0d.%0d] got=%h exp=%h", n, k, dut_word(), e);
            end
         end
      end
      checks++;
      if (err_count !== 8'd255) begin
         failures++;
         $display("[TB] FAIL saturate got=%0d exp=255", err_count);
      end
      applyStimulus(b2g(m_prev + 4'd5), 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if (dut_word() !== e || step_err !== 1'b1 || err_count !== 8'd0) begin
         failures++;
         $display("[TB] FAIL clr_with_bad got=%h exp=%h", dut_word(), e);
      end
      applyStimulus(4'h0, 1'b0, 1'b0);
      void'(sb.pop_front());
   endtask

   task automatic test_async_reset();
      logic [15:0] e;
      applyStimulus(b2g(m_prev + 4'd1), 1'b1, 1'b0);
      void'(sb.pop_front());
      #2 reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_word() !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL async_reset got=%h exp=0000", dut_word());
      end
      reset = 1'b1;
      applyStimulus(4'hD, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (dut_word() !== e || e !== 16'h9800) begin
         failures++;
         $display("[TB] FAIL after_reset got=%h exp=9800", dut_word());
      end
   endtask

   task automatic test_valid_gaps();
      logic [3:0] g[6];
      logic       v[6];
      logic [15:0] e;
      g = '{4'h2, 4'hF, 4'hF, 4'hF, 4'h6, 4'h7};
      v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(g[i], v[i], 1'b0);
         e = sb.pop_front();
         checks++;
         if (dut_word() !== e) begin
            failures++;
            $display("[TB] FAIL gap[%0d] got=%h exp=%h", i, dut_word(), e);
         end
      end
      checks++;
      if (locked !== 1'b1 || bin_out !== 4'd5) begin
         failures++;
         $display("[TB] FAIL gap_inc locked=%b bin=%0d exp locked=1 bin=5", locked, bin_out);
      end
   endtask

   initial begin
      $display("[TB] gray_seq_checker bench start");
      test_reset();
      test_full_sequence();
      test_hold();
      test_step_error();
      test_saturation();
      test_async_reset();
      test_valid_gaps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
